ifetch_byte_sequencer: RTL and testbench

- Fetch front end of PipelineCPU. It reads the byte-wide instruction memory one byte per cycle. This is the reader side of the byte-per-address image that the bench preloads from codigo_validacion.txt.
- Assembles each group of four bytes into a big-endian 32-bit instruction and hands it to decode over a valid/ready handshake.
- Handles branch redirects from EX by flushing any partially assembled word or held word and restarting at the target.

---
 rtl/ifetch_byte_sequencer.sv | 109 ++++++++++
 tb/tb_ifetch_byte_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_byte_sequencer.sv
// Purpose: byte-serial instruction fetch; packs four ROM bytes into a big-endian word for decode.
// Latency: first word valid on the 4th edge after reset release; one word per 5 cycles with decode always ready.
// Backpressure: a completed word is held (no ROM reads) until instr_ready; a branch redirect flushes at any time.
module ifetch_byte_sequencer #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [7:0]            rom_data,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  instr_ready,
    output logic                  instr_valid,
    output logic [31:0]           instruction,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  misalign
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic [1:0]            byte_cnt_q;
    logic [23:0]           asm_q;
    logic                  instr_valid_q;
    logic [31:0]           instruction_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  misalign_q;

    logic [ADDR_WIDTH-1:0] redirect_pc_d;
    logic [ADDR_WIDTH-1:0] next_word_pc_d;
    logic                  misalign_d;

    // Redirect target is forced onto a word boundary; the dropped low bits are reported as misalign.
    always_comb begin
        redirect_pc_d  = {branch_target[ADDR_WIDTH-1:2], 2'b00};
        misalign_d     = (branch_target[1:0] != 2'b00);
        next_word_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
    end

    // ROM address walks the four bytes of the current word; parked on fetch_pc while holding.
    always_comb begin
        if (state_q == S_HOLD) begin
            rom_addr = fetch_pc_q;
        end else begin
            rom_addr = fetch_pc_q + ADDR_WIDTH'(byte_cnt_q);
        end
    end

    // Fetch/hold FSM with assembly and registered outputs; reset, then redirect, take priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            fetch_pc_q    <= RESET_PC;
            byte_cnt_q    <= 2'd0;
            asm_q         <= 24'd0;
            instr_valid_q <= 1'b0;
            instruction_q <= 32'd0;
            pc_q          <= '0;
            misalign_q    <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (branch_taken) begin
                // Any partial or held word is abandoned; a held word that decode
                // accepts on this same edge was already consumed.
                state_q       <= S_FETCH;
                fetch_pc_q    <= redirect_pc_d;
                byte_cnt_q    <= 2'd0;
                instr_valid_q <= 1'b0;
                misalign_q    <= misalign_d;
            end else begin
                case (state_q)
                    S_FETCH: begin
                        case (byte_cnt_q)
                            2'd0: asm_q[23:16] <= rom_data;
                            2'd1: asm_q[15:8]  <= rom_data;
                            2'd2: asm_q[7:0]   <= rom_data;
                            default: begin
                                instruction_q <= {asm_q, rom_data};
                                pc_q          <= fetch_pc_q;
                                instr_valid_q <= 1'b1;
                                fetch_pc_q    <= next_word_pc_d;
                                state_q       <= S_HOLD;
                            end
                        endcase
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                    default: begin
                        if (instr_ready) begin
                            instr_valid_q <= 1'b0;
                            state_q       <= S_FETCH;
                        end
                    end
                endcase
            end
        end
    end

    assign instr_valid = instr_valid_q;
    assign instruction = instruction_q;
    assign pc          = pc_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_ifetch_byte_sequencer.sv
// Purpose: randomized and directed scoreboard bench for the byte-serial fetch front end.
// Latency: reference model predicts every cycle; transfers checked as decode accepts them.
// Backpressure: instr_ready is driven randomly and in long low stretches.
module tb_ifetch_byte_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = 8'd0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [7:0]  pc;
    logic        misalign;

    logic [7:0] mem [256];

    ifetch_byte_sequencer #(.ADDR_WIDTH(8), .RESET_PC(8'd0)) dut (
        .clk           (clk),
        .reset         (reset),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_ready   (instr_ready),
        .instr_valid   (instr_valid),
        .instruction   (instruction),
        .pc            (pc),
        .misalign      (misalign)
    );

    assign rom_data = mem[rom_addr];

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] w;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int n_exp_xfer = 0;
    int n_obs_xfer = 0;
    bit chk_en = 1'b0;

    // Reference model: which word is being fetched, how many byte-cycles into it,
    // whether a finished word is waiting for decode, and the misalign pulse.
    logic [7:0]  m_base = 8'd0;
    int          m_done = 0;
    bit          m_hold = 1'b0;
    logic [7:0]  m_cur_pc = 8'd0;
    logic [31:0] m_word = 32'd0;
    bit          m_mis = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        return {mem[a], mem[a1], mem[a2], mem[a3]};
    endfunction

    // Discard a finished word that decode never took.
    task automatic drop_held(input bit rdy);
        if (m_hold) begin
            if (rdy) n_exp_xfer++;
            else if (sb_q.size() > 0) void'(sb_q.pop_back());
        end
    endtask

    // Advance the model by one clock edge given the inputs seen on that edge.
    task automatic model_edge(input bit r, input bit br, input logic [7:0] tgt, input bit rdy);
        m_mis = 1'b0;
        if (r) begin
            drop_held(rdy);
            m_base = 8'd0;
            m_done = 0;
            m_hold = 1'b0;
        end else if (br) begin
            drop_held(rdy);
            m_base = tgt & 8'hFC;
            m_done = 0;
            m_hold = 1'b0;
            m_mis  = (tgt % 4) != 0;
        end else if (m_hold) begin
            if (rdy) begin
                n_exp_xfer++;
                m_hold = 1'b0;
            end
        end else begin
            m_done++;
            if (m_done == 4) begin
                m_cur_pc = m_base;
                m_word   = word_at(m_base);
                sb_q.push_back('{pc: m_base, w: m_word});
                m_base   = m_base + 8'd4;
                m_done   = 0;
                m_hold   = 1'b1;
            end
        end
    endtask

    task automatic tick(input bit r, input bit br, input logic [7:0] tgt, input bit rdy);
        reset         = r;
        branch_taken  = br;
        branch_target = tgt;
        instr_ready   = rdy;
        @(posedge clk);
        model_edge(r, br, tgt, rdy);
        #1;
    endtask

    // Monitor: cycle-level comparison on the falling edge, scoreboard pop on each accepted word.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("instr_valid", 64'(instr_valid), 64'(m_hold));
            chk("misalign", 64'(misalign), 64'(m_mis));
            if (!m_hold) begin
                chk("rom_addr", 64'(rom_addr), 64'(8'(m_base + 8'(m_done))));
            end else begin
                chk("held_pc", 64'(pc), 64'(m_cur_pc));
                chk("held_instr", 64'(instruction), 64'(m_word));
            end
            if (instr_valid && instr_ready) begin
                n_obs_xfer++;
                chk("xfer_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("xfer_pc", 64'(pc), 64'(e.pc));
                    chk("xfer_word", 64'(instruction), 64'(e.w));
                end
            end
        end
    end

    initial begin
        int n;
        bit found;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hE3; mem[1] = 8'hA0; mem[2] = 8'h10; mem[3] = 8'h05;

        // Reset values
        tick(1, 0, 8'd0, 1);
        chk_en = 1'b1;
        tick(1, 0, 8'd0, 1);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instruction), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_misalign", 64'(misalign), 64'd0);

        // First-word latency and content
        found = 1'b0;
        for (n = 1; n <= 10; n++) begin
            tick(0, 0, 8'd0, 1);
            if (instr_valid) begin found = 1'b1; break; end
        end
        chk("first_found", 64'(found), 64'd1);
        chk("first_latency", 64'(n), 64'd4);
        chk("first_word", 64'(instruction), 64'hE3A01005);
        chk("first_pc", 64'(pc), 64'd0);

        // Second word follows five cycles later
        found = 1'b0;
        for (n = 1; n <= 10; n++) begin
            tick(0, 0, 8'd0, 1);
            if (instr_valid) begin found = 1'b1; break; end
        end
        chk("second_found", 64'(found), 64'd1);
        chk("second_gap", 64'(n), 64'd5);
        chk("second_pc", 64'(pc), 64'd4);

        // Backpressure: hold six cycles, then release
        for (int i = 0; i < 6; i++) tick(0, 0, 8'd0, 0);
        for (int i = 0; i < 6; i++) tick(0, 0, 8'd0, 1);

        // Redirect to 0x20 while byte 2 of a word is being read
        n = 0;
        while (!(m_done == 2 && !m_hold) && n < 20) begin tick(0, 0, 8'd0, 1); n++; end
        if (n >= 20) begin checks++; errors++; $display("FAIL timeout_byte2"); end
        tick(0, 1, 8'h20, 1);
        for (int i = 0; i < 10; i++) tick(0, 0, 8'd0, 1);

        // Misaligned redirect: fetch from 0x10 with a one-cycle misalign pulse
        tick(0, 1, 8'h13, 1);
        chk("misalign_pulse", 64'(misalign), 64'd1);
        tick(0, 0, 8'd0, 1);
        chk("misalign_clear", 64'(misalign), 64'd0);
        for (int i = 0; i < 8; i++) tick(0, 0, 8'd0, 1);

        // Wrap-around from 252 to 0
        for (int i = 0; i < 4; i++) begin
            mem[252 + i] = 8'($urandom);
            mem[i]       = 8'($urandom);
        end
        tick(0, 1, 8'd252, 1);
        for (int i = 0; i < 12; i++) tick(0, 0, 8'd0, 1);

        // Reset while holding with decode stalled
        n = 0;
        while (!m_hold && n < 20) begin tick(0, 0, 8'd0, 0); n++; end
        if (n >= 20) begin checks++; errors++; $display("FAIL timeout_hold"); end
        tick(0, 0, 8'd0, 0);
        tick(1, 0, 8'd0, 0);
        chk("midhold_rst_valid", 64'(instr_valid), 64'd0);
        for (int i = 0; i < 10; i++) tick(0, 0, 8'd0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, br, rdy;
            r   = ($urandom_range(0, 99) == 0);
            br  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            tick(r, br, 8'($urandom), rdy);
        end

        // Drain and reconcile transfer counts
        for (int i = 0; i < 10; i++) tick(0, 0, 8'd0, 1);
        chk("xfer_count", 64'(n_obs_xfer), 64'(n_exp_xfer));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
